// File: rtl/mult_div_pkg.sv
// Shared types and sizing for the HI/LO multiply/divide sequencer.
package mult_div_pkg;

  // Datapath width used by the MIPS core.
  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Width of a counter able to hold the values 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(MD_WIDTH);

endpackage

// File: rtl/mult_div_seq_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, subtract the divisor if it fits, emit one quotient bit.
module div_step
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Trial subtraction; the top bit of trial is the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = {1'b0, shifted} - {2'b00, divisor_i};
    q_o     = ~trial[WIDTH+1];
    // Remainder stays below the divisor, so WIDTH bits always suffice.
    rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle MULT/DIV sequencer producing the HI/LO pair.
// Handshake: start_i is a single-cycle request honoured only while the FSM is
// IDLE; busy_o is high from the accepting edge until the result edge, where
// done_o pulses for one cycle (with div_zero_o when the divisor was zero).
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output state_e           state_o
);

  localparam int unsigned     CW        = cnt_width(WIDTH);
  localparam int unsigned     PW        = 2 * WIDTH + 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;    // {A, Q, q_-1} Booth register
  logic [WIDTH-1:0] mcand_q, mcand_d;  // multiplicand (MULT) or |divisor| (DIV)
  logic [WIDTH-1:0] quo_q, quo_d;      // |dividend| shifts out, quotient shifts in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH:0]   acc_ext, mcand_ext, booth_sum;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[WIDTH-1]),
    .divisor_i (mcand_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Booth radix-2 add/subtract, done one bit wider so that the most negative
  // multiplicand cannot overflow the accumulator before the arithmetic shift.
  always_comb begin
    acc_ext   = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    mcand_ext = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    divz_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          sa_d    = a_i[WIDTH-1];
          sb_d    = b_i[WIDTH-1];
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, b_i, 1'b0};
          mcand_d = (op_i == OP_DIV) ? mag(b_i) : a_i;
          quo_d   = mag(a_i);
          rem_d   = '0;
          dz_d    = (op_i == OP_DIV) && (b_i == '0);
          busy_d  = 1'b1;
          if (op_i == OP_MULT)  state_d = MULT;
          else if (b_i == '0)   state_d = FINISH;
          else                  state_d = DIV;
        end
      end
      MULT: begin
        prod_d = {booth_sum, prod_q[WIDTH:1]};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = FINISH;
      end
      DIV: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = FINISH;
      end
      FINISH: begin
        if (dz_q) begin
          divz_d = 1'b1;
        end else if (op_q == OP_MULT) begin
          {hi_d, lo_d} = prod_q[PW-1:1];
        end else begin
          lo_d = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
          hi_d = sa_q ? (~rem_q + 1'b1) : rem_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = divz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign state_o    = state_q;

endmodule
